// File: rtl/multicycle_core_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_core_if
// Purpose  : Load-port / handshake / observation bundle of multicycle_core.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_core_if #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 8
);
    logic               start;
    logic               I_MEM_Write_Enable;
    logic [IMEM_AW-1:0] MEM_Addr;
    logic [31:0]        InstrIn;
    logic [DATA_W-1:0]  ALUOut;
    logic [IMEM_AW-1:0] PC_out;
    logic               busy;
    logic               halted;

    modport master (
        output start, I_MEM_Write_Enable, MEM_Addr, InstrIn,
        input  ALUOut, PC_out, busy, halted
    );

    modport slave (
        input  start, I_MEM_Write_Enable, MEM_Addr, InstrIn,
        output ALUOut, PC_out, busy, halted
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_core
// Purpose  : Parametrised FETCH/DECODE/EXEC/WB multicycle core with IMEM load port.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_core #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 16,
    parameter int IMEM_AW = 8
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_core_if.slave bus
);
    localparam int RW    = $clog2(NREGS);
    localparam int DEPTH = 1 << IMEM_AW;

    localparam logic [5:0] c_OP_ADD  = 6'h01;
    localparam logic [5:0] c_OP_SUB  = 6'h02;
    localparam logic [5:0] c_OP_AND  = 6'h03;
    localparam logic [5:0] c_OP_OR   = 6'h04;
    localparam logic [5:0] c_OP_XOR  = 6'h05;
    localparam logic [5:0] c_OP_SLT  = 6'h06;
    localparam logic [5:0] c_OP_ADDI = 6'h08;
    localparam logic [5:0] c_OP_BEQ  = 6'h0A;
    localparam logic [5:0] c_OP_JMP  = 6'h0B;
    localparam logic [5:0] c_OP_HALT = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, alu_q, alu_d;
    logic [DATA_W-1:0]  regs_q [NREGS];
    logic [31:0]        imem   [DEPTH];

    logic               rf_we, busy, is_alu, unused_ir;
    logic [5:0]         op;
    logic [RW-1:0]      rd_idx, rs_idx, rt_idx;
    logic [DATA_W-1:0]  imm_sx, alu_res;

    assign op        = ir_q[31:26];
    assign rd_idx    = ir_q[21 +: RW];
    assign rs_idx    = ir_q[16 +: RW];
    assign rt_idx    = ir_q[11 +: RW];
    assign imm_sx    = DATA_W'($signed(ir_q[15:0]));
    assign unused_ir = ^ir_q;

    always_comb begin
        alu_res = '0;
        is_alu  = 1'b1;
        case (op)
            c_OP_ADD:  alu_res    = a_q + b_q;
            c_OP_SUB:  alu_res    = a_q - b_q;
            c_OP_AND:  alu_res    = a_q & b_q;
            c_OP_OR:   alu_res    = a_q | b_q;
            c_OP_XOR:  alu_res    = a_q ^ b_q;
            c_OP_SLT:  alu_res[0] = $signed(a_q) < $signed(b_q);
            c_OP_ADDI: alu_res    = a_q + imm_sx;
            default:   is_alu     = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        rf_we   = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = imem[pc_q];
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // BEQ compares rd against rs, so its operand fields shift by one
                if (op == c_OP_BEQ) begin
                    a_d = regs_q[rd_idx];
                    b_d = regs_q[rs_idx];
                end else begin
                    a_d = regs_q[rs_idx];
                    b_d = regs_q[rt_idx];
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_alu) begin
                    alu_d   = alu_res;
                    state_d = S_WB;
                end else if (op == c_OP_BEQ) begin
                    if (a_q == b_q) pc_d = pc_q + ir_q[IMEM_AW-1:0];
                end else if (op == c_OP_JMP) begin
                    pc_d = ir_q[IMEM_AW-1:0];
                end else if (op == c_OP_HALT) begin
                    state_d = S_HALTED;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            // r0 is never written so it always reads back as zero
            if (rf_we && (rd_idx != '0)) regs_q[rd_idx] <= alu_q;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.I_MEM_Write_Enable && !busy) imem[bus.MEM_Addr] <= bus.InstrIn;
    end

    assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXEC)  || (state_q == S_WB);
    assign bus.busy   = busy;
    assign bus.halted = (state_q == S_HALTED);
    assign bus.ALUOut = alu_q;
    assign bus.PC_out = pc_q;
endmodule
`default_nettype wire

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multicycle processor core: successor to the fixed 32-bit CPU shell, with configurable data width, register count and instruction-memory depth. It has a built-in instruction-memory load port, a start/busy/halted handshake, and a HALT instruction. It runs a small register-register/immediate ISA through a FETCH/DECODE/EXEC/WB state machine. It sits under the top-level test harness, which loads a program, pulses start and observes ALUOut/PC_out.

## Interface
- DATA_W, 32, datapath and register width (≥16)
- NREGS, 16, register-file entries (power of 2, 2..32); r0 reads 0, writes ignored
- IMEM_AW, 8, instruction-memory address bits (depth 2^IMEM_AW words of 32 bits)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution at PC 0; sampled only in IDLE or HALTED
- I_MEM_Write_Enable  in  1  write InstrIn to imem[MEM_Addr] (honoured only when busy=0)
- MEM_Addr  in  IMEM_AW  instruction-memory write address
- InstrIn  in  32  instruction word to load
- ALUOut  out  DATA_W  registered result of the last EXEC
- PC_out  out  IMEM_AW  current program counter
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALTED

## Operation
- Encoding: op=[31:26], rd=[25:21], rs=[20:16], rt=[15:11], imm=[15:0], sign-extended to DATA_W. Register indices use the low log2(NREGS) bits of each field.
- Opcodes:
  - 00 NOP
  - 01 ADD rd=rs+rt
  - 02 SUB rd=rs−rt
  - 03 AND
  - 04 OR
  - 05 XOR
  - 06 SLT: rd=1 if signed rs<rt, else 0
  - 08 ADDI rd=rs+imm
  - 0A BEQ: if R[rd]==R[rs], PC=PC+imm[IMEM_AW-1:0]. PC has already been incremented, so the offset is relative to the next instruction.
  - 0B JMP PC=imm[IMEM_AW-1:0]
  - 3F HALT
  - Any other opcode executes as NOP.
- Arithmetic is modulo 2^DATA_W; overflow is not flagged. PC arithmetic wraps modulo 2^IMEM_AW.
- States:
  - IDLE: on start → FETCH with PC←0.
  - FETCH: IR←imem[PC], PC←PC+1 → DECODE.
  - DECODE: A←R[rs] (R[rd] for BEQ), B←R[rt] (R[rs] for BEQ) → EXEC.
  - EXEC:
    - ALU ops: ALUOut←result → WB.
    - BEQ/JMP: update PC → FETCH.
    - NOP/unknown: → FETCH.
    - HALT: → HALTED.
  - WB: R[rd]←ALUOut → FETCH.
  - HALTED: on start → FETCH with PC←0.
- Branch/JMP/NOP/HALT take 3 cycles; ALU ops take 4 cycles.
- Memory writes:
  - I_MEM_Write_Enable while busy=1 is ignored.
  - In IDLE/HALTED, a write and start in the same cycle both take effect. FETCH on the next cycle sees the new word.
- Register file persists across start; only rst clears it. Instruction memory is not reset.
- ALUOut is updated only in EXEC of ALU ops; it holds otherwise.

## Timing
- Reset values: state=IDLE, PC_out=0, ALUOut=0, busy=0, halted=0, all registers 0, IR/A/B=0.
- rst mid-instruction aborts immediately; any pending WB is lost.
- start asserted at edge N in IDLE gives busy=1 and FETCH from edge N+1. start while busy is ignored.
- A register written in WB is visible to the DECODE of the next instruction (no hazard; strictly sequential).
- halted rises the cycle after EXEC of HALT and stays high until start or rst. PC_out holds the address after the HALT.

## Test plan
- Reset: assert rst mid-run → all outputs 0, state IDLE; after release, start reruns the program from PC 0.
- Arithmetic: ADDI r1,r0,5; ADDI r2,r0,−3; ADD r3,r1,r2; SUB r4,r2,r1; SLT r5,r2,r1; HALT → ALUOut sequence 5, FFFF_FFFD, 2, FFFF_FFF8, 1; halted=1 after 23 cycles; PC_out=6.
- Loop: r1=3, r2=0; loop body ADDI r2,r2,7; ADDI r1,r1,−1; BEQ r1,r0,+1; JMP body; HALT → r2=21 (ALUOut 0 at the last decrement); verify cycle count.
- Boundaries:
  - Write to r0 leaves r0 at 0.
  - JMP to 2^IMEM_AW−1, then the following instruction at PC 0 (wrap) executes.
  - Unknown opcode 0x15 acts as a NOP.
- Handshake:
  - I_MEM_Write_Enable during busy leaves imem unchanged.
  - start while busy is ignored.
  - start in HALTED restarts at PC 0 with registers retained.
- Parametrisation: DATA_W=16, NREGS=8, IMEM_AW=4 → rd field 9 aliases r1; ADD wraps 0x7FFF+1=0x8000; SLT reports 0x8000 < 1.
